// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StFault   = 2'd2
   } hz_state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam int unsigned WAIT_W = 16;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand E-stage forwarding select; the M stage wins over W.
module fwd_sel
   import hazard_pkg::*;
(
   input  logic [4:0] RsE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   output logic [1:0] Fwd
);

   logic w_hit_m;
   logic w_hit_w;

   assign w_hit_m = RegWriteM && (RdM != 5'd0) && (RdM == RsE);
   assign w_hit_w = RegWriteW && (RdW != 5'd0) && (RdW == RsE);

   always_comb begin
      Fwd = FWD_RF;
      if (w_hit_m) begin
         Fwd = FWD_M;
      end else if (w_hit_w) begin
         Fwd = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: forwarding, load-use stall, branch flush, memory freeze
// with bounded wait and sticky fault, plus a saturating stall-cycle counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             ResultSrcE0,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             Fault,
   output logic [CNT_W-1:0] StallCount
);

   localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

   hz_state_e         r_state;
   hz_state_e         w_state_nxt;
   logic [WAIT_W-1:0] r_wait;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              w_lw_stall;
   logic              w_mem_freeze;
   logic              w_freeze;

   fwd_sel u_fwd_a (
      .RsE       (Rs1E),
      .RdM       (RdM),
      .RdW       (RdW),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .Fwd       (ForwardAE)
   );

   fwd_sel u_fwd_b (
      .RsE       (Rs2E),
      .RdM       (RdM),
      .RdW       (RdW),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .Fwd       (ForwardBE)
   );

   assign w_lw_stall   = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
   assign w_mem_freeze = MemReqM && !MemReadyM;

   // While reset is held the state is forced to RUN, so outputs follow the
   // unfrozen RUN equations regardless of the memory handshake.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait;
      w_freeze    = 1'b0;
      if (!reset) begin
         unique case (r_state)
            StRun: begin
               if (w_mem_freeze) begin
                  w_freeze    = 1'b1;
                  w_wait_nxt  = WAIT_W'(1);
                  w_state_nxt = (MaxWait == WAIT_W'(1)) ? StFault : StMemWait;
               end
            end
            StMemWait: begin
               if (MemReadyM) begin
                  w_state_nxt = StRun;
                  w_wait_nxt  = '0;
               end else begin
                  w_freeze   = 1'b1;
                  w_wait_nxt = r_wait + WAIT_W'(1);
                  if (w_wait_nxt == MaxWait) begin
                     w_state_nxt = StFault;
                  end
               end
            end
            StFault: begin
               w_freeze = 1'b1;
            end
            default: begin
               w_state_nxt = StRun;
               w_wait_nxt  = '0;
            end
         endcase
      end
   end

   always_comb begin
      StallF = w_lw_stall;
      StallD = w_lw_stall;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = PCSrcE;
      FlushE = w_lw_stall | PCSrcE;
      FlushW = 1'b0;
      if (w_freeze) begin
         // Holding D/E keeps a resolved branch in E alive until release.
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushD = 1'b0;
         FlushE = 1'b0;
         FlushW = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= StRun;
         r_wait      <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_wait_nxt;
         if (StallF && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign Fault      = (r_state == StFault);
   assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

   localparam int unsigned MaxWait = 4;
   localparam int unsigned CntW    = 8;

   logic            clk;
   logic            reset;
   logic [4:0]      Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic            ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
   logic [1:0]      ForwardAE, ForwardBE;
   logic            StallF, StallD, StallE, StallM;
   logic            FlushD, FlushE, FlushW;
   logic            Fault;
   logic [CntW-1:0] StallCount;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_ctrl #(
      .MAX_WAIT (MaxWait),
      .CNT_W    (CntW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .Rs1D        (Rs1D),
      .Rs2D        (Rs2D),
      .Rs1E        (Rs1E),
      .Rs2E        (Rs2E),
      .RdE         (RdE),
      .RdM         (RdM),
      .RdW         (RdW),
      .ResultSrcE0 (ResultSrcE0),
      .RegWriteM   (RegWriteM),
      .RegWriteW   (RegWriteW),
      .PCSrcE      (PCSrcE),
      .MemReqM     (MemReqM),
      .MemReadyM   (MemReadyM),
      .ForwardAE   (ForwardAE),
      .ForwardBE   (ForwardBE),
      .StallF      (StallF),
      .StallD      (StallD),
      .StallE      (StallE),
      .StallM      (StallM),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .FlushW      (FlushW),
      .Fault       (Fault),
      .StallCount  (StallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       ld, rwm, rww, pc, mreq, mrdy;
      logic [1:0] efa, efb;
      logic [3:0] est;  // {F,D,E,M}
      logic [2:0] efl;  // {D,E,W}
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_idle();
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
      {ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;
   endtask

   task automatic apply(input vec_t v);
      Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
      RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
      ResultSrcE0 = v.ld; RegWriteM = v.rwm; RegWriteW = v.rww;
      PCSrcE = v.pc; MemReqM = v.mreq; MemReadyM = v.mrdy;
   endtask

   function automatic logic [31:0] stalls();
      return {28'd0, StallF, StallD, StallE, StallM};
   endfunction

   function automatic logic [31:0] flushes();
      return {29'd0, FlushD, FlushE, FlushW};
   endfunction

   // Pulse reset between edges, leaving the next cycle to start on a posedge.
   task automatic do_reset();
      @(posedge clk);
      #1;
      set_idle();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      //            rs1d rs2d rs1e rs2e rde rdm rdw ld rwm rww pc mq mr efa    efb    est      efl
      tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000};
      tbl[1]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 4'b0000, 3'b000};
      tbl[2]  = '{0, 0, 5, 0, 0, 0, 5, 0, 1, 1, 0, 0, 0, 2'b01, 2'b00, 4'b0000, 3'b000};
      tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000};
      tbl[4]  = '{0, 0, 0, 9, 0, 9, 9, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 4'b0000, 3'b000};
      tbl[5]  = '{0, 0, 3, 3, 0, 3, 4, 0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 4'b0000, 3'b000};
      tbl[6]  = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b1100, 3'b010};
      tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000};
      tbl[8]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000};
      tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b110};
      tbl[10] = '{7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b1100, 3'b110};
      tbl[11] = '{0, 0, 6, 0, 0, 0, 6, 0, 0, 1, 0, 1, 1, 2'b01, 2'b00, 4'b0000, 3'b000};

      // Reset state, with a load-use pattern present to confirm outputs stay combinational.
      set_idle();
      reset = 1'b1;
      Rs1D = 5'd7; RdE = 5'd7; ResultSrcE0 = 1'b1;
      #2;
      chk("reset_fault", 32'(Fault), 32'd0);
      chk("reset_cnt", 32'(StallCount), 32'd0);
      chk("reset_stall_lw", stalls(), 32'b1100);
      @(posedge clk);
      #1;
      chk("reset_cnt_hold", 32'(StallCount), 32'd0);
      set_idle();
      #1;
      chk("reset_stall_idle", stalls(), 32'b0000);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         next_cycle();
         apply(tbl[i]);
         sample();
         chk($sformatf("vec%0d_fa", i), 32'(ForwardAE), 32'(tbl[i].efa));
         chk($sformatf("vec%0d_fb", i), 32'(ForwardBE), 32'(tbl[i].efb));
         chk($sformatf("vec%0d_stall", i), stalls(), 32'(tbl[i].est));
         chk($sformatf("vec%0d_flush", i), flushes(), 32'(tbl[i].efl));
      end

      // Single load-use cycle counts once.
      do_reset();
      next_cycle();
      ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
      sample();
      chk("lu_stall", stalls(), 32'b1100);
      chk("lu_flush", flushes(), 32'b010);
      next_cycle();
      set_idle();
      sample();
      chk("lu_cnt", 32'(StallCount), 32'd1);
      chk("lu_release", stalls(), 32'b0000);

      // Three wait cycles with a taken branch held in E, then ready.
      do_reset();
      next_cycle();
      MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
      for (int c = 0; c < 3; c++) begin
         sample();
         chk($sformatf("frz%0d_stall", c), stalls(), 32'b1111);
         chk($sformatf("frz%0d_flush", c), flushes(), 32'b001);
         next_cycle();
      end
      MemReadyM = 1'b1;
      sample();
      chk("frz_rel_stall", stalls(), 32'b0000);
      chk("frz_rel_flush", flushes(), 32'b110);
      next_cycle();
      set_idle();
      sample();
      chk("frz_cnt", 32'(StallCount), 32'd3);
      chk("frz_run_stall", stalls(), 32'b0000);
      chk("frz_fault", 32'(Fault), 32'd0);

      // Ready arriving in the cycle the wait counter reaches the limit wins.
      do_reset();
      next_cycle();
      MemReqM = 1'b1; MemReadyM = 1'b0;
      for (int c = 0; c < 3; c++) next_cycle();
      MemReadyM = 1'b1;
      sample();
      chk("edge_rel_stall", stalls(), 32'b0000);
      next_cycle();
      set_idle();
      sample();
      chk("edge_fault", 32'(Fault), 32'd0);
      chk("edge_run_stall", stalls(), 32'b0000);
      chk("edge_cnt", 32'(StallCount), 32'd3);

      // Timeout: fault after the fourth wait cycle, sticky until reset.
      do_reset();
      next_cycle();
      MemReqM = 1'b1; MemReadyM = 1'b0;
      for (int c = 0; c < 3; c++) next_cycle();
      sample();
      chk("to_pre_fault", 32'(Fault), 32'd0);
      next_cycle();
      sample();
      chk("to_fault", 32'(Fault), 32'd1);
      next_cycle();
      MemReqM = 1'b0; MemReadyM = 1'b1; PCSrcE = 1'b1;
      for (int c = 0; c < 3; c++) begin
         sample();
         chk($sformatf("to_sticky%0d", c), 32'(Fault), 32'd1);
         chk($sformatf("to_stall%0d", c), stalls(), 32'b1111);
         chk($sformatf("to_flush%0d", c), flushes(), 32'b001);
         next_cycle();
      end
      reset = 1'b1;
      set_idle();
      #1;
      chk("to_reset_fault", 32'(Fault), 32'd0);
      chk("to_reset_cnt", 32'(StallCount), 32'd0);
      reset = 1'b0;
      sample();
      chk("to_after_stall", stalls(), 32'b0000);

      // Reset asserted in the second MEMWAIT cycle.
      do_reset();
      next_cycle();
      MemReqM = 1'b1; MemReadyM = 1'b0;
      next_cycle();
      next_cycle();
      chk("mw_cnt_before", 32'(StallCount), 32'd2);
      chk("mw_stall_before", stalls(), 32'b1111);
      set_idle();
      reset = 1'b1;
      #1;
      chk("mw_rst_stall", stalls(), 32'b0000);
      chk("mw_rst_cnt", 32'(StallCount), 32'd0);
      chk("mw_rst_fault", 32'(Fault), 32'd0);
      reset = 1'b0;
      next_cycle();
      sample();
      chk("mw_run_stall", stalls(), 32'b0000);

      // Counter saturates at all-ones.
      do_reset();
      next_cycle();
      ResultSrcE0 = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
      for (int c = 0; c < 300; c++) next_cycle();
      chk("sat_cnt", 32'(StallCount), 32'd255);
      set_idle();
      next_cycle();
      chk("sat_hold", 32'(StallCount), 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage RISC-V core. Computes E-stage operand forwarding selects, load-use stalls, and branch-redirect flushes. Freezes the pipeline while data memory is not ready, with a bounded wait and a sticky fault. Its stall and flush outputs drive the en and reset inputs of the F/D/E/M/W stage registers, and it keeps a stall-cycle performance counter.

Parameters:
MAX_WAIT, 255, maximum consecutive memory-wait cycles before fault (1..2^16-1)
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state
Rs1D, Rs2D  in  5  source regs of instruction in D
Rs1E, Rs2E  in  5  source regs of instruction in E
RdE, RdM, RdW  in  5  destination regs in E/M/W
ResultSrcE0  in  1  instruction in E is a load
RegWriteM, RegWriteW  in  1  M/W instruction writes the register file
PCSrcE  in  1  taken branch/jump resolved in E
MemReqM  in  1  M-stage data memory access active
MemReadyM  in  1  data memory completes access this cycle
ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
StallF, StallD, StallE, StallM  out  1  1 = hold stage register (wired to its en)
FlushD, FlushE, FlushW  out  1  1 = load bubble (wired to the stage register reset input)
Fault  out  1  sticky memory-timeout fault
StallCount  out  CNT_W  cycles in which StallF was 1

Behaviour:
- Forwarding (combinational, per operand): 10 if RegWriteM & RdM!=0 & RdM==RsxE; else 01 if RegWriteW & RdW!=0 & RdW==RsxE; else 00. M has priority over W.
- lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- memFreeze = MemReqM & ~MemReadyM.
- FSM states: RUN, MEMWAIT, FAULT. Reset -> RUN, wait counter 0, StallCount 0, Fault 0.
- RUN, memFreeze=0:
  - StallF = StallD = lwStall.
  - StallE = StallM = 0.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - FlushW = 0.
- RUN, memFreeze=1: go to MEMWAIT with wait counter 1, and apply freeze outputs in the same cycle (Mealy).
- Freeze outputs:
  - StallF = StallD = StallE = StallM = 1.
  - FlushW = 1 (bubble into W).
  - FlushD = FlushE = 0, so a taken branch held in E is not lost and redirects after release.
- MEMWAIT:
  - MemReadyM=1: RUN equations apply this cycle; go to RUN; counter cleared.
  - MemReadyM=0: freeze outputs; counter increments.
  - Counter reaches MAX_WAIT with MemReadyM=0: go to FAULT.
  - MemReadyM=1 in the same cycle the counter reaches MAX_WAIT: the ready wins and the FSM goes to RUN.
- FAULT: freeze outputs permanently and Fault=1. Only reset exits FAULT.
- Precedence: freeze > branch flush > load-use. With lwStall and PCSrcE together in RUN, output StallF=StallD=1, FlushD=1, FlushE=1.
- StallCount increments on every cycle with StallF=1 and saturates at all-ones.
- Reset mid-MEMWAIT: FSM immediately returns to RUN, counters clear, and outputs follow the RUN equations with the current inputs.
- Reset values of all outputs are the RUN equations applied to the current inputs, with Fault=0 and StallCount=0. Forward/stall/flush outputs are combinational and are not registered.

Decomposition:
- hazard_pkg holds:
  - state encoding RUN/MEMWAIT/FAULT;
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One sub-module, fwd_sel (RsE, RdM, RdW, RegWriteM, RegWriteW -> 2-bit select), instantiated once per operand.

Test Plan:
- RdM=5, RdW=5, Rs1E=5, both RegWrite=1 -> ForwardAE=10; same with RdM=0 -> ForwardAE=01; Rs2E=0 with RdW=0 -> ForwardBE=00.
- ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=1, FlushE=1 for one cycle; StallCount +1.
- lwStall and PCSrcE both 1 -> StallF=StallD=1, FlushD=FlushE=1.
- MemReqM=1 with MemReadyM low for 3 cycles, then high, and PCSrcE=1 throughout:
  - all Stall*=1, FlushW=1, FlushD=FlushE=0 for 3 cycles;
  - on the 4th cycle FlushD=FlushE=1 and the FSM returns to RUN;
  - StallCount=3.
- MAX_WAIT=4, MemReadyM held 0 -> Fault=1 after the 4th wait cycle; it stays 1 with MemReadyM raised; a reset pulse clears it.
- Assert reset in the 2nd MEMWAIT cycle -> immediate return to RUN with all stalls 0 (idle inputs), StallCount=0, Fault=0.
